led_time_tracker: RTL and testbench

- Downstream consumer of the 100 ms timeout pulse; accumulates elapsed game time as BCD seconds/tenths.
- Drives the LED bar and a time-limit "expired" flag for the asteroid-dodging game.
- Controls the upstream 100 ms timer's enable (timer_en) so time only advances while running.
- Control is via start/pause/clear pulses from the game FSM.

---
 rtl/led_time_tracker_if.sv | 33 +++
 rtl/led_time_tracker.sv | 179 +++++++++++++++++
 tb/tb_led_time_tracker.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/led_time_tracker_if.sv
// Control/status bundle between the game FSM and led_time_tracker.
// master: game FSM side (drives the control pulses).
// slave:  tracker side (drives time digits, LED bar and status).
// Handshake: tick/start/pause/clear are single-cycle strobes sampled on
// posedge clk with no ready/backpressure; every output is registered and
// valid on every cycle.
interface led_time_tracker_if;
  logic       tick;
  logic       start;
  logic       pause;
  logic       clear;
  logic       timer_en;
  logic [3:0] tenths;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [9:0] led;
  logic       sec_pulse;
  logic       running;
  logic       expired;
  logic [1:0] state_dbg;

  modport master (
    output tick, start, pause, clear,
    input  timer_en, tenths, sec_ones, sec_tens, led, sec_pulse,
           running, expired, state_dbg
  );

  modport slave (
    input  tick, start, pause, clear,
    output timer_en, tenths, sec_ones, sec_tens, led, sec_pulse,
           running, expired, state_dbg
  );
endinterface

// File: rtl/led_time_tracker.sv
// led_time_tracker: BCD game-time accumulator driven by the 100 ms tick.
// Counts seconds/tenths while running, flags expiry at LIMIT_SEC.0 and
// drives a tenths thermometer on the LED bar.
// Optional macro LED_BLINK_EN: blink the LED bar in DONE every BLINK_TICKS
// ticks and keep the upstream timer enabled in DONE to supply those ticks.
module led_time_tracker #(
  parameter int LIMIT_SEC   = 60,
  parameter int BLINK_TICKS = 5
) (
  input  logic clk,
  input  logic rst,
  led_time_tracker_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LIM_TENS = 4'(LIMIT_SEC / 10);
  localparam logic [3:0] LIM_ONES = 4'(LIMIT_SEC % 10);

  // Out-of-range parameters would break the expiry compare / blink counter.
  if (LIMIT_SEC < 1 || LIMIT_SEC > 99) begin : g_bad_limit
    $error("led_time_tracker: LIMIT_SEC out of range 1..99");
  end
  if (BLINK_TICKS < 1 || BLINK_TICKS > 15) begin : g_bad_blink
    $error("led_time_tracker: BLINK_TICKS out of range 1..15");
  end

  state_t     state, state_n;
  logic [3:0] tenths_q, tenths_n;
  logic [3:0] ones_q, ones_n;
  logic [3:0] tens_q, tens_n;
  logic       sec_pulse_q, sec_pulse_n;
  logic [3:0] inc_tenths, inc_ones, inc_tens;
  logic       inc_wrap, inc_limit;
  logic [9:0] led_therm;
  logic [9:0] led_done;

`ifdef LED_BLINK_EN
  logic [3:0] blink_q, blink_n;
  logic       phase_q, phase_n;
`endif

  // BCD +0.1 s candidate value and whether it lands exactly on the limit.
  always_comb begin
    inc_wrap   = (tenths_q == 4'd9);
    inc_tenths = inc_wrap ? 4'd0 : tenths_q + 4'd1;
    inc_ones   = ones_q;
    inc_tens   = tens_q;
    if (inc_wrap) begin
      if (ones_q == 4'd9) begin
        inc_ones = 4'd0;
        inc_tens = (tens_q == 4'd9) ? 4'd9 : tens_q + 4'd1;
      end else begin
        inc_ones = ones_q + 4'd1;
      end
    end
    inc_limit = (inc_tenths == 4'd0) && (inc_ones == LIM_ONES) &&
                (inc_tens == LIM_TENS);
  end

  // Next-state, counter and blink decisions; clear overrides everything.
  always_comb begin
    state_n     = state;
    tenths_n    = tenths_q;
    ones_n      = ones_q;
    tens_n      = tens_q;
    sec_pulse_n = 1'b0;
`ifdef LED_BLINK_EN
    blink_n     = blink_q;
    phase_n     = phase_q;
`endif
    if (bus.clear) begin
      state_n  = S_IDLE;
      tenths_n = 4'd0;
      ones_n   = 4'd0;
      tens_n   = 4'd0;
`ifdef LED_BLINK_EN
      blink_n  = 4'd0;
      phase_n  = 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) state_n = S_RUN;
        end
        S_RUN: begin
          if (bus.tick) begin
            tenths_n    = inc_tenths;
            ones_n      = inc_ones;
            tens_n      = inc_tens;
            sec_pulse_n = inc_wrap;
          end
          // Reaching the limit wins over a same-cycle pause.
          if (bus.tick && inc_limit) begin
            state_n = S_DONE;
`ifdef LED_BLINK_EN
            blink_n = 4'd0;
            phase_n = 1'b0;
`endif
          end else if (bus.pause) begin
            state_n = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (bus.start || bus.pause) state_n = S_RUN;
        end
        S_DONE: begin
`ifdef LED_BLINK_EN
          if (bus.tick) begin
            if (blink_q == 4'(BLINK_TICKS - 1)) begin
              blink_n = 4'd0;
              phase_n = ~phase_q;
            end else begin
              blink_n = blink_q + 4'd1;
            end
          end
`endif
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      tenths_q    <= 4'd0;
      ones_q      <= 4'd0;
      tens_q      <= 4'd0;
      sec_pulse_q <= 1'b0;
`ifdef LED_BLINK_EN
      blink_q     <= 4'd0;
      phase_q     <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      tenths_q    <= tenths_n;
      ones_q      <= ones_n;
      tens_q      <= tens_n;
      sec_pulse_q <= sec_pulse_n;
`ifdef LED_BLINK_EN
      blink_q     <= blink_n;
      phase_q     <= phase_n;
`endif
    end
  end

  // Thermometer of the tenths digit: led[i] lit iff i < tenths.
  always_comb begin
    led_therm = '0;
    for (int i = 0; i < 10; i++) begin
      led_therm[i] = (4'(i) < tenths_q);
    end
  end

`ifdef LED_BLINK_EN
  assign led_done     = phase_q ? 10'h000 : 10'h3FF;
  assign bus.timer_en = (state == S_RUN) || (state == S_DONE);
`else
  assign led_done     = 10'h3FF;
  assign bus.timer_en = (state == S_RUN);
`endif

  assign bus.led       = (state == S_DONE) ? led_done : led_therm;
  assign bus.tenths    = tenths_q;
  assign bus.sec_ones  = ones_q;
  assign bus.sec_tens  = tens_q;
  assign bus.sec_pulse = sec_pulse_q;
  assign bus.running   = (state == S_RUN);
  assign bus.expired   = (state == S_DONE);
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_led_time_tracker.sv
// Testbench for led_time_tracker: directed scenarios followed by random
// control/tick traffic, compared every cycle against a model that keeps
// elapsed time as a plain integer count of tenths.
module tb_led_time_tracker;

  localparam int LIMIT = 2;
  localparam int BT    = 2;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  led_time_tracker_if bus ();

  led_time_tracker #(.LIMIT_SEC(LIMIT), .BLINK_TICKS(BT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 run, 2 pause, 3 done
  int m_mode;
  int m_cnt;
  int m_done_ticks;
  bit m_pulse;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit t, input bit s, input bit p,
                            input bit c, input bit r);
    m_pulse = 1'b0;
    if (!r || c) begin
      m_mode = 0;
      m_cnt = 0;
      m_done_ticks = 0;
    end else begin
      case (m_mode)
        0: if (s) m_mode = 1;
        1: begin
          if (t) begin
            m_cnt++;
            if (m_cnt % 10 == 0) m_pulse = 1'b1;
          end
          if (t && m_cnt == LIMIT * 10) begin
            m_mode = 3;
            m_done_ticks = 0;
          end else if (p) begin
            m_mode = 2;
          end
        end
        2: if (s || p) m_mode = 1;
        default: if (t) m_done_ticks++;
      endcase
    end
  endtask

  task automatic check_all();
    logic [9:0] exp_led;
    bit         exp_ten;
    if (m_mode == 3) begin
`ifdef LED_BLINK_EN
      exp_led = ((m_done_ticks / BT) % 2 == 0) ? 10'h3FF : 10'h000;
`else
      exp_led = 10'h3FF;
`endif
    end else begin
      exp_led = 10'((1 << (m_cnt % 10)) - 1);
    end
`ifdef LED_BLINK_EN
    exp_ten = (m_mode == 1) || (m_mode == 3);
`else
    exp_ten = (m_mode == 1);
`endif
    check("tenths",    32'(bus.tenths),    32'(m_cnt % 10));
    check("sec_ones",  32'(bus.sec_ones),  32'((m_cnt / 10) % 10));
    check("sec_tens",  32'(bus.sec_tens),  32'(m_cnt / 100));
    check("led",       32'(bus.led),       32'(exp_led));
    check("sec_pulse", 32'(bus.sec_pulse), 32'(m_pulse));
    check("running",   32'(bus.running),   32'(m_mode == 1));
    check("expired",   32'(bus.expired),   32'(m_mode == 3));
    check("timer_en",  32'(bus.timer_en),  32'(exp_ten));
  endtask

  // Driver: apply one cycle of inputs, then update model and compare.
  task automatic cycle(input bit t, input bit s, input bit p,
                       input bit c, input bit r);
    bus.tick  = t;
    bus.start = s;
    bus.pause = p;
    bus.clear = c;
    rst       = r;
    @(posedge clk);
    #1;
    model_step(t, s, p, c, r);
    check_all();
    bus.tick  = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.clear = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      cycle(1, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 1);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_mode = 0;
    m_cnt = 0;
    m_done_ticks = 0;
    m_pulse = 1'b0;
    bus.tick = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.clear = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Reset, then ticks with no start
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    ticks(20);
    cycle(0, 0, 1, 0, 1);

    // Basic count to 1.3
    cycle(0, 1, 0, 0, 1);
    ticks(13);

    // Pause/resume
    cycle(0, 0, 0, 1, 1);
    cycle(0, 1, 0, 0, 1);
    ticks(5);
    cycle(0, 0, 1, 0, 1);
    ticks(8);
    cycle(1, 1, 0, 0, 1);
    ticks(5);

    // Tick + pause at 0.9
    cycle(0, 0, 0, 1, 1);
    cycle(0, 1, 0, 0, 1);
    ticks(9);
    cycle(1, 0, 1, 0, 1);
    ticks(3);

    // Clear + start + tick together
    cycle(0, 1, 0, 0, 1);
    cycle(1, 1, 0, 1, 1);

    // Expiry, DONE ticks, then clear
    cycle(0, 1, 0, 0, 1);
    ticks(20);
    ticks(7);
    cycle(1, 1, 1, 0, 1);
    cycle(0, 0, 0, 1, 1);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      cycle(bit'($urandom_range(0, 99) < 40),
            bit'($urandom_range(0, 99) < 8),
            bit'($urandom_range(0, 99) < 5),
            bit'($urandom_range(0, 999) < 12),
            bit'($urandom_range(0, 999) >= 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
